fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Controller that sequences the program counter and the instruction-memory fetch handshake for the 32-bit RISC-V core. It issues word fetches, holds each instruction until decode accepts it, and applies branch/jump redirects using a signed byte offset. It sits between the PC datapath, instruction memory and decode. Misaligned targets and memory timeouts set a sticky fault.

Parameters:
PC_W, 10, PC / instruction-memory byte-address width
OFF_W, 20, branch offset width (signed, bytes)
RESET_PC, 0, first fetch address after start
TIMEOUT, 15, max cycles to wait for imem_ack before fault

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  leave IDLE and begin fetching (level, sampled in IDLE only)
stall  input  1  decode not ready; hold delivered instruction
branch  input  1  redirect request, one-cycle pulse
jump_offset  input  OFF_W  signed byte offset, relative to instr_pc
imem_req  output  1  fetch request
imem_addr  output  PC_W  fetch address, equals pc_out
imem_ack  input  1  memory returns data this cycle
imem_rdata  input  32  instruction word, valid with imem_ack
instr_valid  output  1  instr/instr_pc valid for decode
instr  output  32  delivered instruction
instr_pc  output  PC_W  address of delivered / last delivered instruction
pc_out  output  PC_W  current fetch PC
busy  output  1  high when not in IDLE or HALT
fault  output  1  sticky error flag

Behaviour:
- Reset (reset=0, async): state IDLE. pc_out=RESET_PC, instr_pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, busy=0, fault=0, timeout counter=0, pending-redirect flag=0.
- States: IDLE, FETCH, DELIVER, HALT.
- IDLE: if start=1, go to FETCH next cycle.
- FETCH: imem_req=1 and imem_addr=pc_out. Address stays stable until imem_ack. On imem_ack, latch imem_rdata into instr and pc_out into instr_pc, then go to DELIVER. instr_valid rises the cycle after ack. Minimum latency is start to req in 1 cycle, ack to instr_valid in 1 cycle.
- DELIVER: instr_valid=1 and imem_req=0. If stall=0 the instruction is consumed this cycle: pc_out <= pc_out+4, go to FETCH. If stall=1, hold all outputs.
- Target = instr_pc + sign_extend(jump_offset), truncated to PC_W bits (modulo 2^PC_W). pc_out+4 also wraps: 1020 -> 0 for PC_W=10.
- branch in DELIVER: the delivered instruction is accepted regardless of stall. Branch has priority over stall and over PC+4. pc_out <= target, go to FETCH, instr_valid=0 next cycle.
- branch in FETCH: imem_req is not dropped. Record target and set the pending flag. On ack, discard the data (instr_valid stays 0), pc_out <= target, clear pending, stay in FETCH and re-issue. A later branch in the same FETCH overwrites the pending target. If branch and ack occur in the same cycle, treat as pending: data is discarded.
- branch in IDLE or HALT is ignored.
- Misaligned target (target[1:0]!=0): fault <= 1, go to HALT, pc_out unchanged, no request issued.
- Timeout: the counter increments each FETCH cycle without ack and clears on ack or leaving FETCH. Reaching TIMEOUT sets fault and goes to HALT.
- HALT: imem_req=0, instr_valid=0, busy=0, fault=1. Leave only via reset.
- Reset asserted mid-FETCH drops imem_req immediately (async). After reset release, the next fetch address is RESET_PC.

Test Plan:
- Reset low 10 ns, release, start=1, ack 2 cycles after req with rdata=0x00500093 -> imem_addr=0. instr_valid=1, instr=0x00500093, instr_pc=0, then next req at addr 4.
- stall=1 for 3 cycles in DELIVER -> instr_valid and instr held stable, imem_req=0. Stall drops -> next req at instr_pc+4.
- In DELIVER with instr_pc=8, branch=1, jump_offset=196 -> next imem_addr=204. Then jump_offset=800 at instr_pc=204 -> 1004. Then jump_offset=-8 (0xFFFF8) at 1004 -> 996.
- Branch during outstanding FETCH to addr 12 (instr_pc=8, offset 40) -> ack data discarded, no instr_valid, next req at 48. Separately, sequential fetch at 1020 consumed -> next req at 0 (wrap).
- jump_offset=2 -> fault=1, HALT, imem_req=0, busy=0. Separately, imem_ack withheld for 15 cycles -> fault=1.
- Assert reset during FETCH and during HALT -> all outputs return to reset values immediately. After start, the first req is at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: control inputs, instruction-memory handshake,
// decode-side delivery and status.
//   master : fetch_sequencer side (drives imem_req/imem_addr, delivers instr)
//   slave  : environment side (memory, decode, control)
interface fetch_sequencer_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned OFF_W = 20
);
  logic             start;
  logic             stall;
  logic             branch;
  logic [OFF_W-1:0] jump_offset;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [PC_W-1:0]  instr_pc;
  logic [PC_W-1:0]  pc_out;
  logic             busy;
  logic             fault;

  modport master (
    input  start, stall, branch, jump_offset, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_out, busy, fault
  );

  modport slave (
    output start, stall, branch, jump_offset, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_out, busy, fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: sequences the PC, issues word fetches to instruction memory,
// holds each instruction until decode accepts it and applies branch redirects
// (target = instr_pc + signed jump_offset, modulo 2^PC_W).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : fetch_sequencer_if.master (control, imem handshake, decode output,
//           pc_out/busy/fault status)
// Misaligned branch targets and imem_ack timeouts set a sticky fault and park
// the sequencer in HALT until reset.
module fetch_sequencer #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned OFF_W    = 20,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned TIMEOUT  = 15
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.master bus
);

  localparam int unsigned SumW = (OFF_W > PC_W) ? OFF_W : PC_W;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDeliver, StHalt} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   ipc_q, ipc_d;
  logic [31:0]       instr_q, instr_d;
  logic              fault_q, fault_d;
  logic [CntW-1:0]   tmo_q, tmo_d;
  logic              pend_q, pend_d;
  logic [PC_W-1:0]   ptgt_q, ptgt_d;

  logic [PC_W-1:0]   target;
  logic              misaligned;

  // Sign-extend the offset to the wider of the two widths, then wrap to PC_W.
  assign target     = PC_W'(SumW'(ipc_q) + SumW'($signed(bus.jump_offset)));
  assign misaligned = |target[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= PC_W'(RESET_PC);
      ipc_q   <= PC_W'(RESET_PC);
      instr_q <= '0;
      fault_q <= 1'b0;
      tmo_q   <= '0;
      pend_q  <= 1'b0;
      ptgt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      ptgt_q  <= ptgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    tmo_d   = tmo_q;
    pend_d  = pend_q;
    ptgt_d  = ptgt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StFetch;
      end

      StFetch: begin
        if (bus.branch && misaligned) begin
          fault_d = 1'b1;
          state_d = StHalt;
          tmo_d   = '0;
          pend_d  = 1'b0;
        end else if (bus.imem_ack) begin
          tmo_d = '0;
          if (bus.branch || pend_q) begin
            // Data belongs to the abandoned path: drop it and re-issue at the target.
            pc_d   = bus.branch ? target : ptgt_q;
            pend_d = 1'b0;
          end else begin
            instr_d = bus.imem_rdata;
            ipc_d   = pc_q;
            state_d = StDeliver;
          end
        end else begin
          // Keep the request up; the latest branch wins.
          if (bus.branch) begin
            pend_d = 1'b1;
            ptgt_d = target;
          end
          if (tmo_q == CntW'(TIMEOUT - 1)) begin
            fault_d = 1'b1;
            state_d = StHalt;
            tmo_d   = '0;
            pend_d  = 1'b0;
          end else begin
            tmo_d = tmo_q + CntW'(1);
          end
        end
      end

      StDeliver: begin
        // Branch consumes the instruction even when decode is stalled.
        if (bus.branch) begin
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = StHalt;
          end else begin
            pc_d    = target;
            state_d = StFetch;
          end
        end else if (!bus.stall) begin
          pc_d    = pc_q + PC_W'(4);
          state_d = StFetch;
        end
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StHalt;
      end
    endcase
  end

  assign bus.imem_req    = (state_q == StFetch);
  assign bus.imem_addr   = pc_q;
  assign bus.pc_out      = pc_q;
  assign bus.instr_valid = (state_q == StDeliver);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.busy        = (state_q == StFetch) || (state_q == StDeliver);
  assign bus.fault       = fault_q;

endmodule
